// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline sequencing controller.
// The stall-cause enum is shared by the decode and the testbench.
package pipe_ctrl_pkg;

  localparam int DEF_TIMEOUT = 256;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_ERROR
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_DSTALL,
    CAUSE_RHOLD,
    CAUSE_REDIR,
    CAUSE_LOADUSE,
    CAUSE_ISTALL
  } cause_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_clr;
    logic idex_en;
    logic idex_clr;
    logic exmem_en;
    logic exmem_clr;
    logic memwb_en;
    logic memwb_clr;
  } strobe_t;

  // x0 is hardwired, so a load into it never creates a hazard.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic       id_use_rs1,
    input logic [4:0] id_rs2,
    input logic       id_use_rs2
  );
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  endfunction

  function automatic logic is_wait_cause(input cause_e c);
    return (c == CAUSE_DSTALL) || (c == CAUSE_RHOLD) || (c == CAUSE_ISTALL);
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Bus watchdog: counts consecutive wait cycles and flags the one that reaches TIMEOUT.
// TIMEOUT of 0 disables the trip; the counter saturates instead of wrapping.
module pipe_ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  input  logic clear_i,
  output logic trip_o
);

  localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] MAX  = '1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wait_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign trip_o = (TIMEOUT != 0) && wait_i && (cnt_q == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: zero-latency enable/clear strobes from state plus hazard inputs.
// Optional PIPE_CTRL_PERF_EN adds a saturating stall_cnt output.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        if_waitrequest,
  input  logic        dmem_access,
  input  logic        dmem_waitrequest,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_clr,
  output logic        idex_en,
  output logic        idex_clr,
  output logic        exmem_en,
  output logic        exmem_clr,
  output logic        memwb_en,
  output logic        memwb_clr,
  output logic        bus_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  state_e  state_q, state_d;
  cause_e  cause;
  strobe_t st;
  logic    wait_cyc;
  logic    trip;

  // Priority order: data stall, redirect hold, redirect, load-use, fetch stall.
  always_comb begin
    cause = CAUSE_NONE;
    if (dmem_access && dmem_waitrequest) begin
      cause = CAUSE_DSTALL;
    end else if (ex_redirect && if_waitrequest) begin
      cause = CAUSE_RHOLD;
    end else if (ex_redirect) begin
      cause = CAUSE_REDIR;
    end else if (load_use_hit(ex_mem_read, ex_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2)) begin
      cause = CAUSE_LOADUSE;
    end else if (if_waitrequest) begin
      cause = CAUSE_ISTALL;
    end
  end

  assign wait_cyc = (state_q == ST_RUN) && is_wait_cause(cause);

  pipe_ctrl_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_i  (CLK),
    .rst_ni (RST_n),
    .wait_i (wait_cyc),
    .clear_i(!wait_cyc),
    .trip_o (trip)
  );

  always_comb begin
    st      = '0;
    state_d = state_q;
    unique case (state_q)
      ST_INIT: begin
        st.ifid_clr  = 1'b1;
        st.idex_clr  = 1'b1;
        st.exmem_clr = 1'b1;
        st.memwb_clr = 1'b1;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        unique case (cause)
          CAUSE_DSTALL: st.memwb_clr = 1'b1;
          CAUSE_RHOLD: begin
            st.exmem_clr = 1'b1;
            st.memwb_en  = 1'b1;
          end
          CAUSE_REDIR: begin
            st.pc_en    = 1'b1;
            st.ifid_clr = 1'b1;
            st.idex_clr = 1'b1;
            st.exmem_en = 1'b1;
            st.memwb_en = 1'b1;
          end
          CAUSE_LOADUSE: begin
            st.idex_clr = 1'b1;
            st.exmem_en = 1'b1;
            st.memwb_en = 1'b1;
          end
          CAUSE_ISTALL: begin
            st.ifid_clr = 1'b1;
            st.idex_en  = 1'b1;
            st.exmem_en = 1'b1;
            st.memwb_en = 1'b1;
          end
          default: begin
            st.pc_en    = 1'b1;
            st.ifid_en  = 1'b1;
            st.idex_en  = 1'b1;
            st.exmem_en = 1'b1;
            st.memwb_en = 1'b1;
          end
        endcase
        if (trip) begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
          exmem_en, exmem_clr, memwb_en, memwb_clr} = st;
  assign bus_err = (state_q == ST_ERROR);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_RUN) && !st.pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed corner sequences, random vs reference model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TO = 8;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  logic if_waitrequest, dmem_access, dmem_waitrequest;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
  logic exmem_en, exmem_clr, memwb_en, memwb_clr, bus_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  always #5 CLK = ~CLK;

  pipe_ctrl #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .if_waitrequest(if_waitrequest), .dmem_access(dmem_access),
    .dmem_waitrequest(dmem_waitrequest),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
    .idex_en(idex_en), .idex_clr(idex_clr), .exmem_en(exmem_en), .exmem_clr(exmem_clr),
    .memwb_en(memwb_en), .memwb_clr(memwb_clr), .bus_err(bus_err)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic       if_wr, dacc, dwr, redir, exmr;
    logic [4:0] exrd, rs1;
    logic       use1;
    logic [4:0] rs2;
    logic       use2;
  } in_t;

  typedef struct packed {
    logic pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
    logic exmem_en, exmem_clr, memwb_en, memwb_clr, bus_err;
  } outs_t;

  typedef struct {
    string name;
    in_t   in;
    outs_t exp;
  } vec_t;

  // Expected strobe patterns, written out from the rule table.
  localparam outs_t O_N    = 10'b1101010100;
  localparam outs_t O_D    = 10'b0000000010;
  localparam outs_t O_RH   = 10'b0000001100;
  localparam outs_t O_RE   = 10'b1010110100;
  localparam outs_t O_LU   = 10'b0000110100;
  localparam outs_t O_IS   = 10'b0011010100;
  localparam outs_t O_INIT = 10'b0010101010;
  localparam outs_t O_ERR  = 10'b0000000001;

  int checks = 0;
  int errors = 0;

  bit          m_init;
  bit          m_err;
  int          m_waits;
  logic [31:0] m_stalls;

  function automatic in_t mk(input logic if_wr, input logic dacc, input logic dwr,
                             input logic redir, input logic exmr, input logic [4:0] exrd,
                             input logic [4:0] rs1, input logic use1,
                             input logic [4:0] rs2, input logic use2);
    in_t r;
    r.if_wr = if_wr; r.dacc = dacc; r.dwr = dwr; r.redir = redir; r.exmr = exmr;
    r.exrd = exrd; r.rs1 = rs1; r.use1 = use1; r.rs2 = rs2; r.use2 = use2;
    return r;
  endfunction

  function automatic outs_t model_out(input in_t i);
    bit hazard;
    hazard = i.exmr && (i.exrd != 0) &&
             ((i.use1 && i.rs1 == i.exrd) || (i.use2 && i.rs2 == i.exrd));
    if (m_init)             return O_INIT;
    if (m_err)              return O_ERR;
    if (i.dacc && i.dwr)    return O_D;
    if (i.redir && i.if_wr) return O_RH;
    if (i.redir)            return O_RE;
    if (hazard)             return O_LU;
    if (i.if_wr)            return O_IS;
    return O_N;
  endfunction

  function automatic outs_t dut_out();
    return {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
            exmem_en, exmem_clr, memwb_en, memwb_clr, bus_err};
  endfunction

  task automatic cmp(input string nm, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    if_waitrequest = i.if_wr; dmem_access = i.dacc; dmem_waitrequest = i.dwr;
    ex_redirect = i.redir; ex_mem_read = i.exmr; ex_rd = i.exrd;
    id_rs1 = i.rs1; id_use_rs1 = i.use1; id_rs2 = i.rs2; id_use_rs2 = i.use2;
  endtask

  task automatic model_reset();
    m_init = 1; m_err = 0; m_waits = 0; m_stalls = '0;
  endtask

  // Apply one cycle of inputs, compare against the model, then advance the model past the edge.
  task automatic cycle(input string nm, input in_t i, output outs_t act);
    outs_t exp;
    bit    w;
    @(negedge CLK);
    drive(i);
    #1;
    exp = model_out(i);
    act = dut_out();
    cmp(nm, act, exp);
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== m_stalls) begin
      errors++;
      $display("FAIL %s_stall_cnt act=%0d exp=%0d", nm, stall_cnt, m_stalls);
    end
`endif
    if (!RST_n) return;
    if (m_init) begin
      m_init = 0;
    end else if (!m_err) begin
      w = (exp == O_D) || (exp == O_RH) || (exp == O_IS);
      if (w) begin
        if (m_waits == TO - 1) m_err = 1;
        m_waits++;
      end else begin
        m_waits = 0;
      end
      if (!exp.pc_en && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_n = 1'b0;
    drive('0);
    model_reset();
    #1;
    cmp("reset_init", dut_out(), O_INIT);
    repeat (2) @(posedge CLK);
    #1 RST_n = 1'b1;
  endtask

  in_t   Z, IW, RH, RE, LU, DALL, RELU;
  outs_t a;
  vec_t  vt[14];

  initial begin
    Z    = '0;
    IW   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RH   = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    RE   = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    LU   = mk(0, 0, 0, 0, 1, 5'd5, 5'd1, 1, 5'd5, 1);
    DALL = mk(1, 1, 1, 1, 1, 5'd5, 5'd1, 0, 5'd5, 1);
    RELU = mk(0, 0, 0, 1, 1, 5'd5, 5'd1, 0, 5'd5, 1);

    vt[0]  = '{"v_normal",      Z,                                     O_N};
    vt[1]  = '{"v_dacc_nowait", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0),      O_N};
    vt[2]  = '{"v_dstall",      mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0),      O_D};
    vt[3]  = '{"v_dwr_noacc",   mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0),      O_N};
    vt[4]  = '{"v_rhold",       RH,                                    O_RH};
    vt[5]  = '{"v_redir",       RE,                                    O_RE};
    vt[6]  = '{"v_loaduse_rs2", LU,                                    O_LU};
    vt[7]  = '{"v_lu_rd0",      mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1),      O_N};
    vt[8]  = '{"v_lu_nouse",    mk(0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 0, 0), O_N};
    vt[9]  = '{"v_noload",      mk(0, 0, 0, 0, 0, 5'd7, 5'd7, 1, 0, 0), O_N};
    vt[10] = '{"v_istall",      IW,                                    O_IS};
    vt[11] = '{"v_redir_lu",    RELU,                                  O_RE};
    vt[12] = '{"v_dstall_all",  DALL,                                  O_D};
    vt[13] = '{"v_lu_over_is",  mk(1, 0, 0, 0, 1, 5'd7, 5'd7, 1, 0, 0), O_LU};

    // Reset and release: exactly one INIT cycle, then normal.
    drive(Z);
    model_reset();
    repeat (2) @(negedge CLK);
    #1 cmp("in_reset", dut_out(), O_INIT);
    @(posedge CLK);
    #1 RST_n = 1'b1;
    cycle("rel_init", Z, a); cmp("rel_init_c", a, O_INIT);
    cycle("rel_run", Z, a);  cmp("rel_run_c", a, O_N);

    foreach (vt[k]) begin
      cycle(vt[k].name, vt[k].in, a);
      cmp({vt[k].name, "_tbl"}, a, vt[k].exp);
    end

    // Redirect held across a 3-cycle outstanding fetch.
    for (int k = 0; k < 3; k++) begin
      cycle("rh_seq", RH, a); cmp("rh_seq_c", a, O_RH);
    end
    cycle("rh_then_re", RE, a); cmp("rh_then_re_c", a, O_RE);
    cycle("rh_after", Z, a);    cmp("rh_after_c", a, O_N);

    // D-stall dominates redirect and load-use, redirect replays afterwards.
    for (int k = 0; k < 4; k++) begin
      cycle("ds_seq", DALL, a); cmp("ds_seq_c", a, O_D);
    end
    cycle("ds_then_re", RELU, a); cmp("ds_then_re_c", a, O_RE);
    cycle("ds_after", Z, a);

    // Watchdog: 7 waits plus one free cycle is safe, 8 waits trip.
    for (int k = 0; k < TO - 1; k++) cycle("wd_7", IW, a);
    cycle("wd_free", Z, a); cmp("wd_no_err", a, O_N);
    for (int k = 0; k < TO; k++) begin
      cycle("wd_8", IW, a); cmp("wd_8_c", a, O_IS);
    end
    cycle("wd_err", Z, a);   cmp("wd_err_c", a, O_ERR);
    cycle("wd_stuck", RE, a); cmp("wd_stuck_c", a, O_ERR);

    // Asynchronous reset out of ERROR clears the error immediately.
    @(negedge CLK);
    #2 RST_n = 1'b0;
    model_reset();
    #1 cmp("async_rst_err", dut_out(), O_INIT);
    @(posedge CLK);
    #1 RST_n = 1'b1;
    cycle("post_rst_init", Z, a);

    // Reset mid-stall clears the wait count.
    for (int k = 0; k < 5; k++) cycle("mid_stall", IW, a);
    @(negedge CLK);
    #2 RST_n = 1'b0;
    model_reset();
    #1 cmp("async_rst_stall", dut_out(), O_INIT);
    @(posedge CLK);
    #1 RST_n = 1'b1;
    cycle("mid_init", Z, a);
    for (int k = 0; k < TO - 1; k++) cycle("mid_7", IW, a);
    cycle("mid_free", Z, a); cmp("mid_no_err", a, O_N);

`ifdef PIPE_CTRL_PERF_EN
    do_reset();
    cycle("pf_init", Z, a);
    cycle("pf_lu1", LU, a);
    cycle("pf_n1", Z, a);
    cycle("pf_lu2", LU, a);
    cycle("pf_n2", Z, a);
    for (int k = 0; k < 5; k++) cycle("pf_is", IW, a);
    cycle("pf_end", Z, a);
    checks++;
    if (stall_cnt !== 32'd7) begin
      errors++;
      $display("FAIL perf_stall_cnt act=%0d exp=7", stall_cnt);
    end
`endif

    // Random traffic against the reference model, resetting out of ERROR now and then.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      in_t r;
      r = mk($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      cycle("rand", r, a);
      if (m_err && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
